// File: rtl/mbox_pkg.sv
// Shared types and default widths for the MBOX EBOX-request responder.
package mbox_pkg;

    localparam int ADDR_W_DEF = 22;
    localparam int WORD_W_DEF = 36;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_T0    = 3'd1,
        ST_MEM   = 3'd2,
        ST_DONE  = 3'd3,
        ST_RETRY = 3'd4
    } mbox_state_e;

    typedef logic [WORD_W_DEF-1:0] word_t;

endpackage

// File: rtl/mbox_timeout_ctr.sv
// Loadable up-counter that saturates at LIMIT-1 and flags terminal count there.
module mbox_timeout_ctr #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc = (cnt_q == CW'(LIMIT - 1));

    // Next count: clear on load, advance while enabled until terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = {CW{1'b0}};
        end else if (en && !tc) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mbox_ebox_responder.sv
// MBOX responder: accepts EBOX requests, runs one memory cycle each and
// answers with single-cycle T0/retry/page-fail/response/transfer strobes.
module mbox_ebox_responder
    import mbox_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int WORD_W    = WORD_W_DEF,
    parameter int TIMEOUT   = 64,
    parameter int MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              eboxReqIn,
    input  logic              eboxRead,
    input  logic              eboxWrite,
    input  logic [ADDR_W-1:0] eboxAddr,
    input  logic [WORD_W-1:0] eboxDataIn,
    input  logic              pfFail,
    input  logic              memBusy,
    input  logic              memAck,
    input  logic [WORD_W-1:0] memRData,
    output logic              memReq,
    output logic              memWrite,
    output logic [ADDR_W-1:0] memAddr,
    output logic [WORD_W-1:0] memWData,
    output logic              cshEBOXT0,
    output logic              cshEBOXRetry,
    output logic              pfEBOXHandle,
    output logic              mboxRespIn,
    output logic              mboxXfer,
    output logic [WORD_W-1:0] mboxDataOut,
    output logic              nxmErr
);

    localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    mbox_state_e       state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic              pf_hit_q, pf_hit_d;
    logic [RCW-1:0]    retry_cnt_q, retry_cnt_d;
    logic              t0_q, t0_d;
    logic              retry_q, retry_d;
    logic              pf_handle_q, pf_handle_d;
    logic              resp_q, resp_d;
    logic              xfer_q, xfer_d;
    logic              nxm_q, nxm_d;
    logic              ctr_load_s;
    logic              ctr_en_s;
    logic              ctr_tc_s;

    mbox_timeout_ctr #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .load  (ctr_load_s),
        .en    (ctr_en_s),
        .tc    (ctr_tc_s)
    );

    // Next-state and next-output logic; strobes are set on entry to the state they mark.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = 1'b0;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        dout_d      = dout_q;
        pf_hit_d    = pf_hit_q;
        retry_cnt_d = retry_cnt_q;
        t0_d        = 1'b0;
        retry_d     = 1'b0;
        pf_handle_d = 1'b0;
        resp_d      = 1'b0;
        xfer_d      = 1'b0;
        nxm_d       = 1'b0;
        ctr_load_s  = 1'b0;
        ctr_en_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (eboxReqIn && (eboxRead ^ eboxWrite)) begin
                    // Page fail is sampled here so its strobe lines up with T0.
                    state_d     = ST_T0;
                    t0_d        = 1'b1;
                    mem_addr_d  = eboxAddr;
                    mem_wdata_d = eboxDataIn;
                    mem_write_d = eboxWrite;
                    pf_hit_d    = pfFail;
                    pf_handle_d = pfFail;
                end else if (eboxReqIn && eboxRead && eboxWrite) begin
                    state_d = ST_RETRY;
                    retry_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_T0: begin
                if (pf_hit_q) begin
                    state_d = ST_IDLE;
                end else if (memBusy) begin
                    state_d = ST_RETRY;
                    if (retry_cnt_q == RCW'(MAX_RETRY)) begin
                        nxm_d       = 1'b1;
                        xfer_d      = 1'b1;
                        retry_cnt_d = {RCW{1'b0}};
                    end else begin
                        retry_d     = 1'b1;
                        retry_cnt_d = retry_cnt_q + RCW'(1);
                    end
                end else begin
                    state_d    = ST_MEM;
                    mem_req_d  = 1'b1;
                    ctr_load_s = 1'b1;
                end
            end
            ST_MEM: begin
                ctr_en_s = 1'b1;
                if (memAck) begin
                    state_d = ST_DONE;
                    xfer_d  = 1'b1;
                    resp_d  = !mem_write_q;
                    if (!mem_write_q) begin
                        dout_d = memRData;
                    end else begin
                        dout_d = dout_q;
                    end
                end else if (ctr_tc_s) begin
                    state_d = ST_DONE;
                    xfer_d  = 1'b1;
                    resp_d  = !mem_write_q;
                    nxm_d   = 1'b1;
                    if (!mem_write_q) begin
                        dout_d = {WORD_W{1'b0}};
                    end else begin
                        dout_d = dout_q;
                    end
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                retry_cnt_d = {RCW{1'b0}};
            end
            ST_RETRY: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and strobe registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {WORD_W{1'b0}};
            dout_q      <= {WORD_W{1'b0}};
            pf_hit_q    <= 1'b0;
            retry_cnt_q <= {RCW{1'b0}};
            t0_q        <= 1'b0;
            retry_q     <= 1'b0;
            pf_handle_q <= 1'b0;
            resp_q      <= 1'b0;
            xfer_q      <= 1'b0;
            nxm_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            dout_q      <= dout_d;
            pf_hit_q    <= pf_hit_d;
            retry_cnt_q <= retry_cnt_d;
            t0_q        <= t0_d;
            retry_q     <= retry_d;
            pf_handle_q <= pf_handle_d;
            resp_q      <= resp_d;
            xfer_q      <= xfer_d;
            nxm_q       <= nxm_d;
        end
    end

    assign memReq       = mem_req_q;
    assign memWrite     = mem_write_q;
    assign memAddr      = mem_addr_q;
    assign memWData     = mem_wdata_q;
    assign cshEBOXT0    = t0_q;
    assign cshEBOXRetry = retry_q;
    assign pfEBOXHandle = pf_handle_q;
    assign mboxRespIn   = resp_q;
    assign mboxXfer     = xfer_q;
    assign mboxDataOut  = dout_q;
    assign nxmErr       = nxm_q;

endmodule

// File: doc/mbox_ebox_responder.md
Name: mbox_ebox_responder

Overview:
MBOX-side responder for the EBOX memory request interface. It accepts EBOX read/write requests, checks the pager page-fail flag, and runs one physical memory cycle per request on a simple req/ack memory port. It answers the EBOX with the cache T0, retry, response, transfer and page-fail-handle strobes. It sits between the EBOX control logic and the memory port, timed by the single MBOX clock.

Parameters:
ADDR_W, 22, physical address width (KL10 22-bit physical space)
WORD_W, 36, data word width
TIMEOUT, 64, cycles to wait for memAck before declaring non-existent memory (NXM)
MAX_RETRY, 3, retries issued on busy before forcing NXM

Ports:
clk  in  1  MBOX clock
reset  in  1  synchronous, active-high
eboxReqIn  in  1  EBOX request; level, held until mboxXfer/cshEBOXRetry/pfEBOXHandle
eboxRead  in  1  read request qualifier
eboxWrite  in  1  write request qualifier
eboxAddr  in  ADDR_W  physical address
eboxDataIn  in  WORD_W  write data
pfFail  in  1  pager page-fail for eboxAddr, valid while eboxReqIn=1
memBusy  in  1  memory port busy (cannot accept memReq)
memAck  in  1  one-cycle completion from memory
memRData  in  WORD_W  read data, valid with memAck
memReq  out  1  memory cycle request, held until memAck
memWrite  out  1  memory cycle direction
memAddr  out  ADDR_W  registered address
memWData  out  WORD_W  registered write data
cshEBOXT0  out  1  pulse: request accepted (T0)
cshEBOXRetry  out  1  pulse: EBOX must reissue
pfEBOXHandle  out  1  pulse: page fail, no memory cycle
mboxRespIn  out  1  pulse: mboxDataOut valid (reads only)
mboxXfer  out  1  pulse: transfer complete (read or write)
mboxDataOut  out  WORD_W  registered read data, held until next read
nxmErr  out  1  pulse: non-existent memory

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Synchronous reset mid-cycle drops memReq on the next edge, with no EBOX strobe.
- States: IDLE, T0, MEM, DONE, RETRY.
- IDLE: if eboxReqIn and exactly one of eboxRead/eboxWrite, go to T0 next cycle. Neither qualifier set: stay IDLE. Both set: go to RETRY (illegal request).
- T0: pulse cshEBOXT0. Latch addr, data and direction.
  - pfFail=1: pulse pfEBOXHandle in the same cycle, go to IDLE, no memReq.
  - Else memBusy=1: go to RETRY.
  - Else assert memReq, go to MEM.
- MEM: hold memReq/memWrite/memAddr/memWData stable. Count cycles.
  - memAck: drop memReq; for a read, latch memRData into mboxDataOut; go to DONE.
  - Count reaches TIMEOUT with no ack: drop memReq, pulse nxmErr, force mboxDataOut=0 for reads, go to DONE.
  - memAck on the exact TIMEOUT cycle: ack wins, no nxmErr.
- DONE: pulse mboxXfer. For reads, also pulse mboxRespIn in the same cycle. Clear the retry count. Go to IDLE.
  - Minimum read latency: eboxReqIn sampled, then T0 at +1 and memReq at +1; memAck in cycle n gives mboxRespIn at n+1.
- RETRY: pulse cshEBOXRetry, increment the retry count, go to IDLE.
  - When count = MAX_RETRY, the busy path instead pulses nxmErr plus mboxXfer and clears the count.
  - An illegal request always retries; it is not counted.
- eboxReqIn deasserted after T0: the memory cycle still completes and DONE strobes still fire; the EBOX ignores them.
- memAck outside MEM: ignored.
- Every strobe is exactly one cycle wide.
- Back-to-back: IDLE accepts a new request in the cycle after DONE, so a new T0 occurs 2 cycles after DONE.

Decomposition:
- Shared package mbox_pkg holds:
  - state enum (IDLE, T0, MEM, DONE, RETRY)
  - ADDR_W/WORD_W defaults
  - the word type
- One sub-module, mbox_timeout_ctr: loadable up-counter with a terminal-count flag, reused for the TIMEOUT watchdog.
- The retry counter stays inline.

Test Plan:
- Read, addr 22'o1234567, memAck after 3 cycles with data 36'o123456701234 -> cshEBOXT0 at +1, memReq held 3 cycles, mboxRespIn and mboxXfer same cycle, mboxDataOut=36'o123456701234.
- Write, addr 22'o000100, data 36'o777777000000 -> memWrite=1, memWData matches, mboxXfer pulse, mboxRespIn stays 0.
- Read with pfFail=1 -> cshEBOXT0 and pfEBOXHandle same cycle, memReq never asserted, no mboxXfer.
- memBusy held high, MAX_RETRY=3 -> 3 cshEBOXRetry pulses on successive requests, then the 4th request gives nxmErr plus mboxXfer.
- Read, memAck never arrives, TIMEOUT=64 -> memReq high exactly 64 cycles, then nxmErr, mboxRespIn, mboxDataOut=0.
- Reset asserted while in MEM -> memReq 0 on the next edge, no strobes, and a new request afterward completes normally.
